tape_recorder: RTL and testbench
================================

Name: tape_recorder

Overview:
- Capture side of the PET cassette path: timestamps the PET's cass_write pulse stream and encodes it as TAP v1 pulse bytes.
- Bytes are buffered in a small FIFO that the IO controller drains through a valid/ready port, producing a .TAP image of whatever the PET SAVEs.
- Counterpart of the existing tape player, which turns TAP bytes into cass_read. Sits beside it in the top level, clocked from the system clock, timed by the 500 kHz tape clock enable.

Parameters:
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries (16).
LONG_THRESH, 1024, tick count at or above which a pulse is emitted in long (4-byte) form.

Ports:
clk  in  1  system clock (56 MHz).
reset_n  in  1  synchronous reset, active-low.
ce_500k  in  1  one-clk-wide tick, 500 kHz (2 us per tick).
rec_en  in  1  recording armed (IO controller).
cass_motor_n  in  1  PET motor control, active-low.
cass_write  in  1  PET cassette write data.
dout  out  8  FIFO head byte.
dout_valid  out  1  FIFO non-empty.
dout_ready  in  1  consumer accepts dout this clk.
overflow  out  1  sticky: at least one pulse record dropped.
byte_count  out  24  total bytes pushed since recording armed.

Behaviour:
- Reset (reset_n=0 at posedge clk): FIFO empty, dout_valid=0, dout=0, overflow=0, byte_count=0, tick counter=0, armed=0, FSM=IDLE.
- Active = rec_en & !cass_motor_n.
- cass_write passes through a 2-flop synchronizer. A falling edge is sync[1]=0 while the previous sync value was 1.
- Tick counter, 23 bits:
  - increments on ce_500k while active;
  - saturates at 0x7FFFFF;
  - clears to 0 on each detected falling edge and whenever not active.
- armed:
  - cleared whenever not active;
  - set by the first falling edge while active. That edge emits nothing.
- Each later falling edge while armed latches T = counter value (before clear) into a record:
  - Short form, T < LONG_THRESH: one byte = T>>2; if T>>2 == 0, emit 0x01 (0x00 is reserved).
  - Long form, T >= LONG_THRESH: four bytes, in order 0x00, P[7:0], P[15:8], P[23:16], where P = {T,1'b0} (microseconds, 24 bits).
- Free-space check:
  - A record is accepted only if the FIFO has free entries ≥ record length, evaluated on the edge cycle.
  - Otherwise the whole record is dropped (never partial) and overflow is set.
- FSM states: IDLE, EMIT_S, EMIT_L0, EMIT_L1, EMIT_L2, EMIT_L3. Transitions:
  - IDLE -> EMIT_S or EMIT_L0 on an accepted edge.
  - EMIT_S -> IDLE.
  - EMIT_L0 -> EMIT_L1 -> EMIT_L2 -> EMIT_L3 -> IDLE.
  - Each state pushes one byte the next clk.
  - Total latency from edge detect to last push: 1 clk (short) or 4 clk (long).
  - Edges cannot arrive during emission (minimum pulse spacing ≫ 4 clk). An edge seen while not IDLE is still latched into a one-deep pending register and emitted after IDLE is re-entered.
- FIFO:
  - Push and pop in the same clk are both performed; count is unchanged.
  - A pop when empty is ignored.
  - dout shows the head combinationally from a registered read pointer.
  - dout_valid = count != 0.
  - Pointers wrap modulo depth.
- byte_count:
  - increments by 1 per push;
  - wraps at 2**24;
  - clears on the rising edge of rec_en.
- overflow clears on the rising edge of rec_en or on reset only.
- Motor off or rec_en low mid-record: an FSM already emitting finishes its record. Counter and armed clear. FIFO contents are kept for draining.

Optional Feature:
TAPREC_GLITCH_FILTER_EN:
- Defined: the synchronized cass_write feeds a filter that updates its output only after the input has held a new level for 8 consecutive clk. Edge detection uses the filter output. Adds 8 clk to edge latency; pulses shorter than 8 clk are ignored.
- Undefined: edge detection uses the synchronizer output directly.

Test Plan:
- Reset with rec_en=1, motor on; drive 5 falling edges spaced 352 ticks -> first edge emits nothing; FIFO receives 4 bytes of 0x58; byte_count=4; overflow=0.
- Two edges spaced 2 ticks -> single byte 0x01.
- Two edges spaced 5000 ticks -> bytes 0x00, 0x10, 0x27, 0x00 in order (P=10000).
- dout_ready held 0; generate 17 short pulses -> 16 bytes stored; 17th dropped; overflow=1. With 14 entries used, a long pulse -> whole record dropped; FIFO count stays 14.
- Drop cass_motor_n high mid-gap, re-enable, then edge -> no byte emitted (re-arm). Pulse reset_n low during EMIT_L1 -> all outputs return to reset values next clk.
- Hold dout_ready=1 while pushing -> simultaneous push/pop keeps count steady. Byte order at dout matches push order.

Source files
------------

// File: rtl/tape_recorder_if.sv
// Byte stream from the tape recorder FIFO to the IO controller (valid/ready).
interface tape_recorder_if;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/tape_recorder.sv
// PET cassette capture: timestamps cass_write falling edges and emits TAP v1 pulse bytes via a FIFO.
// Optional build macro TAPREC_GLITCH_FILTER_EN adds an 8-clk level filter after the synchronizer.
module tape_recorder #(
  parameter int FIFO_AW     = 4,
  parameter int LONG_THRESH = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_500k,
  input  logic        rec_en,
  input  logic        cass_motor_n,
  input  logic        cass_write,
  tape_recorder_if.master tap,
  output logic        overflow,
  output logic [23:0] byte_count
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LONG_LEN  = (FIFO_AW+1)'(4);
  localparam logic [FIFO_AW:0] SHORT_LEN = (FIFO_AW+1)'(1);
  localparam logic [22:0]      CNT_MAX   = 23'h7F_FFFF;
  localparam logic [22:0]      LONG_T    = 23'(LONG_THRESH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EMIT_S  = 3'd1,
    EMIT_L0 = 3'd2,
    EMIT_L1 = 3'd3,
    EMIT_L2 = 3'd4,
    EMIT_L3 = 3'd5
  } state_t;

  state_t             state_r, state_nx;
  logic [1:0]         sync_r;
  logic               lvl_s, lvl_d_r, fall_s;
  logic               active_s, rec_en_d_r, rec_rise_s, rec_evt_s;
  logic [22:0]        tick_r, t_r, pend_t_r, launch_t_s;
  logic               armed_r, pend_v_r, pend_set_s, pend_clr_s;
  logic               launch_s, launch_long_s, drop_s;
  logic               push_s, push_ok_s, pop_s;
  logic [7:0]         push_byte_s, short_byte_s;
  logic [23:0]        p_s;
  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]   count_r, free_s;

  assign active_s   = rec_en & ~cass_motor_n;
  assign rec_rise_s = rec_en & ~rec_en_d_r;

  // Two-flop synchronizer for the asynchronous PET write line
  always_ff @(posedge clk) begin
    if (!reset_n) sync_r <= 2'b00;
    else          sync_r <= {sync_r[0], cass_write};
  end

`ifdef TAPREC_GLITCH_FILTER_EN
  logic       filt_r;
  logic [2:0] filt_cnt_r;

  // Level filter: follow the input only after it has held a new level for 8 clk
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_r     <= 1'b0;
      filt_cnt_r <= 3'd0;
    end else if (sync_r[1] != filt_r) begin
      if (filt_cnt_r == 3'd7) begin
        filt_r     <= sync_r[1];
        filt_cnt_r <= 3'd0;
      end else begin
        filt_cnt_r <= filt_cnt_r + 3'd1;
      end
    end else begin
      filt_cnt_r <= 3'd0;
    end
  end
  assign lvl_s = filt_r;
`else
  assign lvl_s = sync_r[1];
`endif

  assign fall_s    = lvl_d_r & ~lvl_s;
  assign rec_evt_s = active_s & armed_r & fall_s;

  // Edge history and rec_en history for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lvl_d_r    <= 1'b0;
      rec_en_d_r <= 1'b0;
    end else begin
      lvl_d_r    <= lvl_s;
      rec_en_d_r <= rec_en;
    end
  end

  // Pulse-width tick counter and arming; the first edge after activation only arms
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_r  <= 23'd0;
      armed_r <= 1'b0;
    end else if (!active_s) begin
      tick_r  <= 23'd0;
      armed_r <= 1'b0;
    end else begin
      if (fall_s)                              tick_r <= 23'd0;
      else if (ce_500k && (tick_r != CNT_MAX)) tick_r <= tick_r + 23'd1;
      if (fall_s) armed_r <= 1'b1;
    end
  end

  assign free_s       = DEPTH_C - count_r;
  assign p_s          = {t_r, 1'b0};
  assign short_byte_s = (t_r[9:2] == 8'h00) ? 8'h01 : t_r[9:2];

  // Record emission FSM: launch/accept/drop decision in IDLE, one pushed byte per EMIT state
  always_comb begin
    state_nx      = state_r;
    push_s        = 1'b0;
    push_byte_s   = 8'h00;
    launch_s      = 1'b0;
    launch_t_s    = tick_r;
    launch_long_s = 1'b0;
    drop_s        = 1'b0;
    pend_set_s    = 1'b0;
    pend_clr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_v_r) begin
          launch_s   = 1'b1;
          launch_t_s = pend_t_r;
          pend_clr_s = 1'b1;
          pend_set_s = rec_evt_s;
        end else if (rec_evt_s) begin
          launch_s   = 1'b1;
          launch_t_s = tick_r;
        end else begin
          launch_s   = 1'b0;
        end
        launch_long_s = (launch_t_s >= LONG_T);
        if (launch_s) begin
          if (launch_long_s && (free_s >= LONG_LEN))       state_nx = EMIT_L0;
          else if (!launch_long_s && (free_s >= SHORT_LEN)) state_nx = EMIT_S;
          else                                               drop_s   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      EMIT_S:  begin push_s = 1'b1; push_byte_s = short_byte_s; pend_set_s = rec_evt_s; state_nx = IDLE;    end
      EMIT_L0: begin push_s = 1'b1; push_byte_s = 8'h00;        pend_set_s = rec_evt_s; state_nx = EMIT_L1; end
      EMIT_L1: begin push_s = 1'b1; push_byte_s = p_s[7:0];     pend_set_s = rec_evt_s; state_nx = EMIT_L2; end
      EMIT_L2: begin push_s = 1'b1; push_byte_s = p_s[15:8];    pend_set_s = rec_evt_s; state_nx = EMIT_L3; end
      EMIT_L3: begin push_s = 1'b1; push_byte_s = p_s[23:16];   pend_set_s = rec_evt_s; state_nx = IDLE;    end
      default: begin state_nx = IDLE; end
    endcase
  end

  // FSM state, latched pulse width, one-deep pending edge and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      t_r      <= 23'd0;
      pend_v_r <= 1'b0;
      pend_t_r <= 23'd0;
      overflow <= 1'b0;
    end else begin
      state_r <= state_nx;
      if (launch_s && !drop_s) t_r <= launch_t_s;
      if (pend_set_s) begin
        pend_v_r <= 1'b1;
        pend_t_r <= tick_r;
      end else if (pend_clr_s) begin
        pend_v_r <= 1'b0;
      end
      if (rec_rise_s)  overflow <= 1'b0;
      else if (drop_s) overflow <= 1'b1;
    end
  end

  // Space was reserved at launch; the guard only protects against a full FIFO
  assign push_ok_s = push_s & ((count_r != DEPTH_C) | pop_s);
  assign pop_s     = tap.dout_ready & (count_r != {(FIFO_AW+1){1'b0}});

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_byte_s;
  end

  // FIFO pointers, occupancy and pushed-byte counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r   <= {FIFO_AW{1'b0}};
      rd_ptr_r   <= {FIFO_AW{1'b0}};
      count_r    <= {(FIFO_AW+1){1'b0}};
      byte_count <= 24'd0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
      if (pop_s)     rd_ptr_r <= rd_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
      if (push_ok_s && !pop_s)      count_r <= count_r + SHORT_LEN;
      else if (pop_s && !push_ok_s) count_r <= count_r - SHORT_LEN;
      if (rec_rise_s)     byte_count <= 24'd0;
      else if (push_ok_s) byte_count <= byte_count + 24'd1;
    end
  end

  assign tap.dout_valid = (count_r != {(FIFO_AW+1){1'b0}});
  assign tap.dout       = tap.dout_valid ? mem_r[rd_ptr_r] : 8'h00;

endmodule

// File: tb/tb_tape_recorder.sv
// Randomized bench for tape_recorder against a queue-based TAP encoding model.
module tb_tape_recorder;
  logic        clk = 1'b0;
  logic        reset_n, ce_500k, rec_en, cass_motor_n, cass_write;
  logic        overflow;
  logic [23:0] byte_count;
  tape_recorder_if tap();

  tape_recorder #(.FIFO_AW(4), .LONG_THRESH(1024)) dut (
    .clk(clk), .reset_n(reset_n), .ce_500k(ce_500k), .rec_en(rec_en),
    .cass_motor_n(cass_motor_n), .cass_write(cass_write), .tap(tap.master),
    .overflow(overflow), .byte_count(byte_count));

  always #5 clk = ~clk;

  int checks_n = 0;
  int fails_n  = 0;
  int pops_n   = 0;

  // model state
  logic [7:0] exp_q [$];
  int         gap_m   = 0;
  bit         armed_m = 1'b0;
  bit         ovf_m   = 1'b0;
  int         byte_m  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      fails_n++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit active_m();
    return rec_en && !cass_motor_n;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // n ticks of the tape clock enable, one every 3 clk
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      ce_500k = 1'b1; step();
      ce_500k = 1'b0; step(); step();
      if (active_m() && gap_m < 32'h7F_FFFF) gap_m++;
    end
  endtask

  task automatic model_record(input int t);
    logic [7:0] b [$];
    logic [23:0] p;
    if (t < 1024) begin
      b.push_back(((t >> 2) == 0) ? 8'h01 : 8'(t >> 2));
    end else begin
      p = 24'(t) << 1;
      b.push_back(8'h00); b.push_back(p[7:0]); b.push_back(p[15:8]); b.push_back(p[23:16]);
    end
    if (16 - exp_q.size() >= b.size()) begin
      foreach (b[i]) exp_q.push_back(b[i]);
      byte_m = (byte_m + b.size()) & 32'hFF_FFFF;
    end else begin
      ovf_m = 1'b1;
    end
  endtask

  task automatic fall_edge();
    cass_write = 1'b0;
    if (active_m()) begin
      if (armed_m) model_record(gap_m);
      armed_m = 1'b1;
      gap_m   = 0;
    end
    repeat (6) step();
    cass_write = 1'b1;
    step();
  endtask

  task automatic status(input string tag);
    repeat (4) step();
    check_val({tag, "_byte_count"}, {8'h00, byte_count}, 32'(byte_m));
    check_val({tag, "_overflow"}, {31'd0, overflow}, {31'd0, ovf_m});
  endtask

  task automatic drain(input string tag);
    tap.dout_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    step(); step();
    check_val({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_valid_empty"}, {31'd0, tap.dout_valid}, 32'd0);
  endtask

  // scoreboard: each accepted handshake must present the next modelled byte
  always @(negedge clk) begin
    if (reset_n && tap.dout_valid && tap.dout_ready) begin
      pops_n++;
      check_val("dout", {24'h0, tap.dout}, (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 32'h100);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d", checks_n);
    $fatal(1, "timeout");
  end

  initial begin
    int base, exp_bc, bnd [4];
    reset_n = 1'b0; ce_500k = 1'b0; rec_en = 1'b1; cass_motor_n = 1'b0;
    cass_write = 1'b1; tap.dout_ready = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    @(negedge clk);
    check_val("rst_valid", {31'd0, tap.dout_valid}, 32'd0);
    check_val("rst_dout", {24'h0, tap.dout}, 32'd0);
    check_val("rst_overflow", {31'd0, overflow}, 32'd0);
    check_val("rst_byte_count", {8'h0, byte_count}, 32'd0);
    step();

    // five edges 352 ticks apart, held in the FIFO
    fall_edge();
    for (int i = 0; i < 4; i++) begin ticks(352); fall_edge(); end
    status("five");
    check_val("five_valid", {31'd0, tap.dout_valid}, 32'd1);
    drain("five");

    // streaming with simultaneous push/pop: min, long, threshold boundaries, random
    tap.dout_ready = 1'b1;
    ticks(2);    fall_edge();
    ticks(5000); fall_edge();
    bnd = '{255, 256, 1023, 1024};
    foreach (bnd[i]) begin ticks(bnd[i]); fall_edge(); end
    for (int i = 0; i < 5; i++) begin ticks($urandom_range(1, 1200)); fall_edge(); end
    status("stream");
    drain("stream");

    // fill with 17 short records: the last one is dropped
    tap.dout_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin ticks($urandom_range(4, 200)); fall_edge(); end
    status("fill");
    check_val("fill_valid", {31'd0, tap.dout_valid}, 32'd1);
    tap.dout_ready = 1'b1; step(); step(); tap.dout_ready = 1'b0;
    ticks(1500); fall_edge();
    status("long_drop");
    base = pops_n;
    drain("long_drop");
    check_val("kept_14", 32'(pops_n - base), 32'd14);

    // reset while the long record is half emitted
    tap.dout_ready = 1'b0;
    ticks(2500);
    cass_write = 1'b0;
    model_record(gap_m);
    exp_bc = (byte_m - 3) & 32'hFF_FFFF;
    repeat (4) step();
    @(negedge clk);
    check_val("mid_valid", {31'd0, tap.dout_valid}, 32'd1);
    check_val("mid_byte_count", {8'h0, byte_count}, 32'(exp_bc));
    reset_n = 1'b0;
    step();
    @(negedge clk);
    check_val("mrst_valid", {31'd0, tap.dout_valid}, 32'd0);
    check_val("mrst_dout", {24'h0, tap.dout}, 32'd0);
    check_val("mrst_overflow", {31'd0, overflow}, 32'd0);
    check_val("mrst_byte_count", {8'h0, byte_count}, 32'd0);
    cass_write = 1'b1;
    exp_q.delete(); byte_m = 0; ovf_m = 1'b0; armed_m = 1'b0; gap_m = 0;
    step(); step();
    reset_n = 1'b1;
    step(); step();

    // motor off mid-gap forces re-arming
    tap.dout_ready = 1'b1;
    fall_edge();
    ticks(100);
    cass_motor_n = 1'b1; armed_m = 1'b0; gap_m = 0;
    repeat (3) step();
    cass_motor_n = 1'b0;
    ticks(100); fall_edge();
    status("rearm");
    ticks(300); fall_edge();
    status("after_rearm");
    drain("after_rearm");

    // rec_en rising edge clears the byte counter
    rec_en = 1'b0; armed_m = 1'b0; gap_m = 0;
    step(); step();
    rec_en = 1'b1; byte_m = 0; ovf_m = 1'b0;
    status("rec_rise");

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end
endmodule
